// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage: branch resolve, data-memory req/ready transfer, registered writeback.
// Optional MEM_MISALIGN_CHECK_EN: misaligned memory ops raise mem_exc instead of issuing a request.
module mem_stage #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_in,
    input  logic [31:0]       alu_result,
    input  logic [4:0]        write_addr,
    input  logic [31:0]       store_data,
    input  logic              zero,
    input  logic [15:0]       branch_target,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              MemtoReg,
    input  logic              RegWrite,
    input  logic              Branch,
    output logic              mem_stall,
    output logic              pc_src,
    output logic [15:0]       pc_target,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    input  logic [31:0]       dmem_rdata,
    input  logic              dmem_ready,
    output logic              wb_valid,
    output logic              wb_regwrite,
    output logic [4:0]        wb_addr,
    output logic [31:0]       wb_data,
    output logic              mem_exc
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state_q;
    logic              dmem_we_q;
    logic [ADDR_W-1:0] dmem_addr_q;
    logic [31:0]       dmem_wdata_q;
    logic [4:0]        wr_addr_q;
    logic              regwrite_q;
    logic              memtoreg_q;
    logic [31:0]       alu_q;
    logic              wb_valid_q;
    logic              wb_regwrite_q;
    logic [4:0]        wb_addr_q;
    logic [31:0]       wb_data_q;
    logic              pc_src_q;
    logic [15:0]       pc_target_q;
    logic              mem_exc_q;

    logic is_mem;
    logic misaligned;

    assign is_mem = MemRead | MemWrite;

`ifdef MEM_MISALIGN_CHECK_EN
    assign misaligned = (alu_result[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            dmem_we_q     <= 1'b0;
            dmem_addr_q   <= '0;
            dmem_wdata_q  <= '0;
            wr_addr_q     <= '0;
            regwrite_q    <= 1'b0;
            memtoreg_q    <= 1'b0;
            alu_q         <= '0;
            wb_valid_q    <= 1'b0;
            wb_regwrite_q <= 1'b0;
            wb_addr_q     <= '0;
            wb_data_q     <= '0;
            pc_src_q      <= 1'b0;
            pc_target_q   <= '0;
            mem_exc_q     <= 1'b0;
        end else begin
            wb_valid_q <= 1'b0;
            pc_src_q   <= 1'b0;
            mem_exc_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (valid_in) begin
                        if (is_mem && misaligned) begin
                            wb_valid_q    <= 1'b1;
                            wb_regwrite_q <= 1'b0;
                            wb_addr_q     <= write_addr;
                            wb_data_q     <= '0;
                            mem_exc_q     <= 1'b1;
                        end else if (is_mem) begin
                            // Load wins when both MemRead and MemWrite are set.
                            dmem_we_q    <= MemWrite & ~MemRead;
                            dmem_addr_q  <= alu_result[ADDR_W+1:2];
                            dmem_wdata_q <= store_data;
                            wr_addr_q    <= write_addr;
                            regwrite_q   <= RegWrite;
                            memtoreg_q   <= MemtoReg;
                            alu_q        <= alu_result;
                            state_q      <= BUSY;
                        end else begin
                            wb_valid_q    <= 1'b1;
                            wb_regwrite_q <= RegWrite;
                            wb_addr_q     <= write_addr;
                            wb_data_q     <= alu_result;
                            pc_src_q      <= Branch & zero;
                            pc_target_q   <= branch_target;
                        end
                    end
                end
                BUSY: begin
                    if (dmem_ready) begin
                        state_q    <= IDLE;
                        wb_valid_q <= 1'b1;
                        wb_addr_q  <= wr_addr_q;
                        if (dmem_we_q) begin
                            wb_regwrite_q <= 1'b0;
                            wb_data_q     <= '0;
                        end else begin
                            wb_regwrite_q <= regwrite_q;
                            wb_data_q     <= memtoreg_q ? dmem_rdata : alu_q;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Stall and request come straight from state so reset drops them at once.
    assign mem_stall   = (state_q == BUSY);
    assign dmem_req    = (state_q == BUSY);
    assign dmem_we     = dmem_we_q;
    assign dmem_addr   = dmem_addr_q;
    assign dmem_wdata  = dmem_wdata_q;
    assign pc_src      = pc_src_q;
    assign pc_target   = pc_target_q;
    assign wb_valid    = wb_valid_q;
    assign wb_regwrite = wb_regwrite_q;
    assign wb_addr     = wb_addr_q;
    assign wb_data     = wb_data_q;
    assign mem_exc     = mem_exc_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage using a cycle-indexed expectation schedule.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in;
    logic [31:0] alu_result;
    logic [4:0]  write_addr;
    logic [31:0] store_data;
    logic        zero;
    logic [15:0] branch_target;
    logic        MemRead, MemWrite, MemtoReg, RegWrite, Branch;
    logic        mem_stall, pc_src, dmem_req, dmem_we;
    logic [15:0] pc_target;
    logic [9:0]  dmem_addr;
    logic [31:0] dmem_wdata, dmem_rdata;
    logic        dmem_ready;
    logic        wb_valid, wb_regwrite;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        mem_exc;

    mem_stage #(.ADDR_W(10)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .alu_result(alu_result),
        .write_addr(write_addr), .store_data(store_data), .zero(zero),
        .branch_target(branch_target), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .Branch(Branch),
        .mem_stall(mem_stall), .pc_src(pc_src), .pc_target(pc_target),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
        .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_addr(wb_addr),
        .wb_data(wb_data), .mem_exc(mem_exc)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Expected outputs per cycle; data fields are only consulted when their flag is set.
    bit          e_wbv[1024];
    bit          e_pcs[1024];
    bit          e_stall[1024];
    bit          e_exc[1024];
    bit          e_chkd[1024];
    logic        e_regw[1024];
    logic [4:0]  e_addr[1024];
    logic [31:0] e_data[1024];
    logic [15:0] e_tgt[1024];
    logic        e_we[1024];
    logic [9:0]  e_daddr[1024];
    logic [31:0] e_wdata[1024];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", nm, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("wb_valid", {31'b0, wb_valid}, {31'b0, e_wbv[cyc]});
            chk("pc_src", {31'b0, pc_src}, {31'b0, e_pcs[cyc]});
            chk("mem_stall", {31'b0, mem_stall}, {31'b0, e_stall[cyc]});
            chk("dmem_req", {31'b0, dmem_req}, {31'b0, e_stall[cyc]});
            chk("mem_exc", {31'b0, mem_exc}, {31'b0, e_exc[cyc]});
            if (e_wbv[cyc]) begin
                chk("wb_regwrite", {31'b0, wb_regwrite}, {31'b0, e_regw[cyc]});
                if (e_chkd[cyc]) begin
                    chk("wb_addr", {27'b0, wb_addr}, {27'b0, e_addr[cyc]});
                    chk("wb_data", wb_data, e_data[cyc]);
                end
            end
            if (e_pcs[cyc])
                chk("pc_target", {16'b0, pc_target}, {16'b0, e_tgt[cyc]});
            if (e_stall[cyc]) begin
                chk("dmem_we", {31'b0, dmem_we}, {31'b0, e_we[cyc]});
                chk("dmem_addr", {22'b0, dmem_addr}, {22'b0, e_daddr[cyc]});
                chk("dmem_wdata", dmem_wdata, e_wdata[cyc]);
            end
        end
    end

    task automatic drive_zero();
        valid_in = 1'b0; alu_result = '0; write_addr = '0; store_data = '0;
        zero = 1'b0; branch_target = '0; MemRead = 1'b0; MemWrite = 1'b0;
        MemtoReg = 1'b0; RegWrite = 1'b0; Branch = 1'b0;
    endtask

    task automatic idle(input int n, input logic rdy);
        repeat (n) begin
            @(posedge clk); #2;
            drive_zero();
            dmem_ready = rdy;
            dmem_rdata = $urandom;
        end
    endtask

    // Present one bundle; for a memory op, drive lat BUSY cycles with junk upstream
    // bundles and assert dmem_ready in the last one.
    task automatic op(input logic mr, input logic mw, input logic m2r, input logic rw,
                      input logic br, input logic z, input logic [31:0] alu,
                      input logic [31:0] sd, input logic [4:0] wa, input logic [15:0] bt,
                      input int lat, input logic [31:0] rdata);
        int c;
        bit mis;
        @(posedge clk); #2;
        c = cyc;
        valid_in = 1'b1; MemRead = mr; MemWrite = mw; MemtoReg = m2r; RegWrite = rw;
        Branch = br; zero = z; alu_result = alu; store_data = sd; write_addr = wa;
        branch_target = bt; dmem_ready = 1'b0;
        mis = 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
        mis = (mr | mw) && (alu[1:0] != 2'b00);
`endif
        if (!(mr | mw)) begin
            e_wbv[c+1] = 1'b1; e_chkd[c+1] = 1'b1; e_regw[c+1] = rw;
            e_addr[c+1] = wa; e_data[c+1] = alu;
            e_pcs[c+1] = br & z; e_tgt[c+1] = bt;
        end else if (mis) begin
            e_wbv[c+1] = 1'b1; e_chkd[c+1] = 1'b0; e_regw[c+1] = 1'b0; e_exc[c+1] = 1'b1;
        end else begin
            for (int k = 1; k <= lat; k++) begin
                e_stall[c+k] = 1'b1;
                e_we[c+k]    = mw & ~mr;
                e_daddr[c+k] = alu[11:2];
                e_wdata[c+k] = sd;
            end
            e_wbv[c+lat+1]  = 1'b1;
            e_chkd[c+lat+1] = 1'b1;
            e_addr[c+lat+1] = wa;
            if (mr) begin
                e_regw[c+lat+1] = rw;
                e_data[c+lat+1] = m2r ? rdata : alu;
            end else begin
                e_regw[c+lat+1] = 1'b0;
                e_data[c+lat+1] = 32'h0;
            end
            for (int k = 1; k <= lat; k++) begin
                @(posedge clk); #2;
                valid_in = 1'b1; MemWrite = 1'b1; MemRead = 1'($urandom);
                MemtoReg = 1'b1; RegWrite = 1'b1; Branch = 1'b1; zero = 1'b1;
                alu_result = $urandom; store_data = $urandom;
                write_addr = 5'($urandom); branch_target = 16'($urandom);
                dmem_ready = (k == lat);
                dmem_rdata = (k == lat) ? rdata : $urandom;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drive_zero();
        dmem_ready = 1'b0;
        dmem_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wb_valid", {31'b0, wb_valid}, 32'h0);
        chk("rst_dmem_req", {31'b0, dmem_req}, 32'h0);
        chk("rst_mem_stall", {31'b0, mem_stall}, 32'h0);
        chk("rst_pc_src", {31'b0, pc_src}, 32'h0);
        chk("rst_wb_data", wb_data, 32'h0);
        chk("rst_dmem_addr", {22'b0, dmem_addr}, 32'h0);
        chk("rst_mem_exc", {31'b0, mem_exc}, 32'h0);
        #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // ALU op
        op(0, 0, 0, 1, 0, 0, 32'h0000_002A, 32'h0, 5'd5, 16'h0, 0, 32'h0);
        idle(1, 1'b0);
        @(negedge clk);
        chk("lit_alu_wb_valid", {31'b0, wb_valid}, 32'h1);
        chk("lit_alu_wb_addr", {27'b0, wb_addr}, 32'd5);
        chk("lit_alu_wb_data", wb_data, 32'h2A);

        // Taken branch, then not taken
        op(0, 0, 0, 0, 1, 1, 32'h0, 32'h0, 5'd0, 16'h0040, 0, 32'h0);
        idle(1, 1'b0);
        @(negedge clk);
        chk("lit_br_pc_src", {31'b0, pc_src}, 32'h1);
        chk("lit_br_pc_target", {16'b0, pc_target}, 32'h0040);
        chk("lit_br_wb_regwrite", {31'b0, wb_regwrite}, 32'h0);
        op(0, 0, 0, 0, 1, 0, 32'h0, 32'h0, 5'd0, 16'h0040, 0, 32'h0);
        idle(1, 1'b0);
        @(negedge clk);
        chk("lit_nbr_pc_src", {31'b0, pc_src}, 32'h0);

        // Load, three-cycle memory latency
        op(1, 0, 1, 1, 0, 0, 32'h0000_0010, 32'h0, 5'd8, 16'h0, 3, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("lit_ld_stall", {31'b0, mem_stall}, 32'h1);
        chk("lit_ld_dmem_addr", {22'b0, dmem_addr}, 32'd4);
        idle(1, 1'b0);
        @(negedge clk);
        chk("lit_ld_wb_data", wb_data, 32'hDEAD_BEEF);
        chk("lit_ld_wb_addr", {27'b0, wb_addr}, 32'd8);
        chk("lit_ld_wb_regwrite", {31'b0, wb_regwrite}, 32'h1);

        // Store, immediate ready
        op(0, 1, 0, 1, 0, 0, 32'h0000_0008, 32'h1234_5678, 5'd9, 16'h0, 1, 32'h0);
        @(negedge clk);
        chk("lit_st_dmem_we", {31'b0, dmem_we}, 32'h1);
        chk("lit_st_dmem_addr", {22'b0, dmem_addr}, 32'd2);
        chk("lit_st_dmem_wdata", dmem_wdata, 32'h1234_5678);
        idle(1, 1'b0);
        @(negedge clk);
        chk("lit_st_wb_valid", {31'b0, wb_valid}, 32'h1);
        chk("lit_st_wb_regwrite", {31'b0, wb_regwrite}, 32'h0);

        // Back-to-back mix
        op(0, 0, 0, 1, 0, 0, 32'h11, 32'h0, 5'd1, 16'h0, 0, 32'h0);
        op(0, 0, 0, 1, 1, 1, 32'h22, 32'h0, 5'd2, 16'h1234, 0, 32'h0);
        op(1, 0, 0, 1, 1, 1, 32'h100, 32'h0, 5'd3, 16'h5555, 1, 32'hCAFE_F00D);
        op(0, 0, 0, 0, 0, 1, 32'h33, 32'h0, 5'd4, 16'h0, 0, 32'h0);
        op(1, 1, 1, 1, 0, 0, 32'h3FC, 32'hAAAA_5555, 5'd6, 16'h0, 2, 32'h0BAD_C0DE);
        op(0, 1, 0, 1, 0, 0, 32'hFFF0, 32'h5A5A, 5'd7, 16'h0, 2, 32'h0);
        op(0, 0, 0, 1, 1, 1, 32'h44, 32'h0, 5'd10, 16'hBEEF, 0, 32'h0);
        idle(2, 1'b1);

        // Misaligned load
        op(1, 0, 1, 1, 0, 0, 32'h0000_0006, 32'h0, 5'd3, 16'h0, 2, 32'h7777_0000);
        idle(1, 1'b0);
`ifdef MEM_MISALIGN_CHECK_EN
        @(negedge clk);
        chk("lit_mis_mem_exc", {31'b0, mem_exc}, 32'h1);
        chk("lit_mis_wb_valid", {31'b0, wb_valid}, 32'h1);
        chk("lit_mis_dmem_req", {31'b0, dmem_req}, 32'h0);
`endif
        idle(3, 1'b0);

        // Reset in the middle of a transfer
        chk_en = 1'b0;
        @(posedge clk); #2;
        valid_in = 1'b1; MemRead = 1'b1; MemtoReg = 1'b1; RegWrite = 1'b1;
        alu_result = 32'h20; write_addr = 5'd9; dmem_ready = 1'b0;
        @(posedge clk); #2;
        drive_zero();
        @(negedge clk);
        chk("rst2_pre_stall", {31'b0, mem_stall}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst2_dmem_req", {31'b0, dmem_req}, 32'h0);
        chk("rst2_mem_stall", {31'b0, mem_stall}, 32'h0);
        chk("rst2_wb_valid", {31'b0, wb_valid}, 32'h0);
        chk("rst2_pc_src", {31'b0, pc_src}, 32'h0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        dmem_ready = 1'b1;
        @(negedge clk);
        chk("rst2_idle_stall", {31'b0, mem_stall}, 32'h0);
        chk("rst2_idle_req", {31'b0, dmem_req}, 32'h0);
        chk_en = 1'b1;
        op(0, 0, 0, 1, 0, 0, 32'h55, 32'h0, 5'd12, 16'h0, 0, 32'h0);
        idle(3, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
